alu_result_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_result_stage_if.sv | 34 +++
 rtl/alu_result_stage_flag_gen.sv | 24 ++
 rtl/alu_result_stage.sv | 104 ++++++++++
 tb/tb_alu_result_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions, occupancy states, entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // Bit positions of the NZCV nibble, {N,Z,C,V} from MSB to LSB.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Widths of the default-configured entry (ALU BITS and register tag width).
    localparam int ENTRY_BITS   = 4;
    localparam int ENTRY_DEST_W = 3;

    // Occupancy of a single buffer slot.
    typedef enum logic {
        OCC_EMPTY = 1'b0,
        OCC_FULL  = 1'b1
    } occ_e;

    // One buffered write-back entry at the default widths.
    typedef struct packed {
        logic [ENTRY_BITS-1:0]   result;
        logic [ENTRY_DEST_W-1:0] dest;
        logic [3:0]              flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake and payload bundle between the ALU, the result stage and write-back.
// Latency: n/a (wires only).
// Backpressure: ready_o gates the upstream side, ready_i gates the downstream side.
interface alu_result_stage_if #(
    parameter int BITS   = 4,
    parameter int DEST_W = 3
);
    logic              valid_i;
    logic              ready_o;
    logic [BITS-1:0]   result_i;
    logic              carry_i;
    logic              ovf_i;
    logic              set_flags_i;
    logic [DEST_W-1:0] dest_i;
    logic              flush_i;
    logic              valid_o;
    logic              ready_i;
    logic [BITS-1:0]   result_o;
    logic [DEST_W-1:0] dest_o;
    logic [3:0]        flags_o;
    logic [3:0]        status_o;

    // Stage side.
    modport slave (
        input  valid_i, result_i, carry_i, ovf_i, set_flags_i, dest_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, dest_o, flags_o, status_o
    );

    // Driver / observer side.
    modport master (
        output valid_i, result_i, carry_i, ovf_i, set_flags_i, dest_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, dest_o, flags_o, status_o
    );
endinterface

// File: rtl/alu_result_stage_flag_gen.sv
// Derives the NZCV nibble of an ALU result.
// Latency: combinational.
// Backpressure: none.
module flag_gen
    import alu_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] result_i,
    input  logic            carry_i,
    input  logic            ovf_i,
    output logic [3:0]      flags_o
);

    // Sign from the MSB, zero from a full compare, carry/overflow passed through.
    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_N] = result_i[BITS-1];
        flags_o[FLAG_Z] = (result_i == '0);
        flags_o[FLAG_C] = carry_i;
        flags_o[FLAG_V] = ovf_i;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer for ALU results with per-entry flags and an NZCV status register.
// Latency: 1 cycle from input transfer to valid_o when the main entry is free or draining.
// Backpressure: ready_o is registered and drops only while the skid entry holds an entry.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int BITS   = 4,
    parameter int DEST_W = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    alu_result_stage_if.slave    bus
);

    typedef struct packed {
        logic [BITS-1:0]   result;
        logic [DEST_W-1:0] dest;
        logic [3:0]        flags;
    } stage_entry_t;

    occ_e         main_st;
    occ_e         skid_st;
    stage_entry_t main_q;
    stage_entry_t skid_q;
    logic [3:0]   status_q;

    logic [3:0]   in_flags;
    stage_entry_t in_entry;
    logic         in_xfer;

    flag_gen #(
        .BITS (BITS)
    ) u_flag_gen (
        .result_i (bus.result_i),
        .carry_i  (bus.carry_i),
        .ovf_i    (bus.ovf_i),
        .flags_o  (in_flags)
    );

    // Assemble the incoming entry and qualify the input handshake.
    always_comb begin
        in_entry        = '0;
        in_entry.result = bus.result_i;
        in_entry.dest   = bus.dest_i;
        in_entry.flags  = in_flags;
        in_xfer         = bus.valid_i && (skid_st == OCC_EMPTY);
    end

    // Occupancy FSMs, payload and status; reset beats flush, flush beats handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            main_st  <= OCC_EMPTY;
            skid_st  <= OCC_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            status_q <= 4'b0000;
        end else if (bus.flush_i) begin
            // Payload is left as is; it is meaningless once both slots are empty.
            main_st <= OCC_EMPTY;
            skid_st <= OCC_EMPTY;
        end else begin
            if (in_xfer && bus.set_flags_i) begin
                status_q <= in_flags;
            end
            case (main_st)
                OCC_EMPTY: begin
                    // Skid is never occupied while main is empty.
                    if (in_xfer) begin
                        main_q  <= in_entry;
                        main_st <= OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (bus.ready_i) begin
                        if (skid_st == OCC_FULL) begin
                            // ready_o is low here, so no input competes with the refill.
                            main_q  <= skid_q;
                            skid_st <= OCC_EMPTY;
                        end else if (in_xfer) begin
                            main_q <= in_entry;
                        end else begin
                            main_st <= OCC_EMPTY;
                        end
                    end else if (in_xfer) begin
                        skid_q  <= in_entry;
                        skid_st <= OCC_FULL;
                    end
                end
                default: begin
                    main_st <= OCC_EMPTY;
                    skid_st <= OCC_EMPTY;
                end
            endcase
        end
    end

    assign bus.ready_o  = (skid_st == OCC_EMPTY);
    assign bus.valid_o  = (main_st == OCC_FULL);
    assign bus.result_o = main_q.result;
    assign bus.dest_o   = main_q.dest;
    assign bus.flags_o  = main_q.flags;
    assign bus.status_o = status_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios followed by random traffic.
// Latency: n/a.
// Backpressure: downstream ready is driven directly and randomised.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int BITS   = 4;
    localparam int DEST_W = 3;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   n_cmp;
    int   n_err;

    alu_entry_t exp_q[$];
    logic [3:0] exp_status;

    alu_result_stage_if #(.BITS(BITS), .DEST_W(DEST_W)) bus ();

    alu_result_stage #(
        .BITS   (BITS),
        .DEST_W (DEST_W)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference flags straight from the definition of N, Z, C, V.
    function automatic logic [3:0] ref_flags(input int r, input bit c, input bit v);
        logic [3:0] f;
        f    = 4'b0000;
        f[3] = (r >= (1 << (BITS - 1)));
        f[2] = (r == 0);
        f[1] = c;
        f[0] = v;
        return f;
    endfunction

    // Model: runs just after the falling edge, after the monitor has popped.
    initial begin
        forever begin
            alu_entry_t e;
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                exp_status = 4'b0000;
            end else if (bus.flush_i) begin
                exp_q.delete();
            end else if (bus.valid_i && bus.ready_o) begin
                e.result = bus.result_i;
                e.dest   = bus.dest_i;
                e.flags  = ref_flags(int'(bus.result_i), bus.carry_i, bus.ovf_i);
                exp_q.push_back(e);
                if (bus.set_flags_i) exp_status = e.flags;
            end
        end
    end

    // Monitor: compares occupancy, status and every output transfer.
    initial begin
        forever begin
            alu_entry_t e;
            @(negedge clk);
            if (chk_en) begin
                chk("valid_o", 32'(bus.valid_o), 32'(exp_q.size() > 0));
                chk("ready_o", 32'(bus.ready_o), 32'(exp_q.size() < 2));
                chk("status_o", 32'(bus.status_o), 32'(exp_status));
                if (bus.valid_o && bus.ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out: got result %0h, expected no entry", bus.result_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_result", 32'(bus.result_o), 32'(e.result));
                        chk("out_dest", 32'(bus.dest_o), 32'(e.dest));
                        chk("out_flags", 32'(bus.flags_o), 32'(e.flags));
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input bit c, input bit v, input bit sf, input logic [2:0] d);
        bus.valid_i     = 1'b1;
        bus.result_i    = r;
        bus.carry_i     = c;
        bus.ovf_i       = v;
        bus.set_flags_i = sf;
        bus.dest_i      = d;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid_o"}, 32'(bus.valid_o), 32'd0);
        chk({tag, "_ready_o"}, 32'(bus.ready_o), 32'd1);
        chk({tag, "_status_o"}, 32'(bus.status_o), 32'd0);
        chk({tag, "_result_o"}, 32'(bus.result_o), 32'd0);
        chk({tag, "_dest_o"}, 32'(bus.dest_o), 32'd0);
        chk({tag, "_flags_o"}, 32'(bus.flags_o), 32'd0);
    endtask

    initial begin
        logic [3:0] stream [3];
        logic [3:0] stream_f [3];
        logic [3:0] saved;
        n_cmp  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        bus.valid_i = 1'b0; bus.result_i = '0; bus.carry_i = 1'b0; bus.ovf_i = 1'b0;
        bus.set_flags_i = 1'b0; bus.dest_i = '0; bus.flush_i = 1'b0; bus.ready_i = 1'b1;
        cyc();
        cyc();
        check_reset_values("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Zero result with carry updates both entry flags and status.
        push(4'h0, 1'b1, 1'b0, 1'b1, 3'd5);
        cyc();
        bus.valid_i = 1'b0;
        chk("first_valid", 32'(bus.valid_o), 32'd1);
        chk("first_result", 32'(bus.result_o), 32'd0);
        chk("first_flags", 32'(bus.flags_o), 32'b0110);
        chk("first_status", 32'(bus.status_o), 32'b0110);
        cyc();

        // Back-to-back stream at full throughput.
        stream[0] = 4'h8; stream[1] = 4'h3; stream[2] = 4'hF;
        stream_f[0] = 4'b1000; stream_f[1] = 4'b0000; stream_f[2] = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            push(stream[i], 1'b0, 1'b0, 1'b0, 3'(i));
            cyc();
            chk("stream_ready", 32'(bus.ready_o), 32'd1);
            chk("stream_result", 32'(bus.result_o), 32'(stream[i]));
            chk("stream_flags", 32'(bus.flags_o), 32'(stream_f[i]));
        end
        bus.valid_i = 1'b0;
        cyc();

        // Status holds when set_flags is low.
        push(4'h8, 1'b0, 1'b0, 1'b1, 3'd1);
        cyc();
        push(4'h0, 1'b0, 1'b0, 1'b0, 3'd2);
        cyc();
        bus.valid_i = 1'b0;
        chk("nosf_flags", 32'(bus.flags_o), 32'b0100);
        chk("nosf_status", 32'(bus.status_o), 32'b1000);
        cyc();

        // Stall fills the skid entry, release drains in order.
        bus.ready_i = 1'b0;
        push(4'h1, 1'b0, 1'b0, 1'b0, 3'd3);
        cyc();
        push(4'h2, 1'b0, 1'b0, 1'b0, 3'd4);
        cyc();
        bus.valid_i = 1'b0;
        chk("stall_ready", 32'(bus.ready_o), 32'd0);
        chk("stall_result", 32'(bus.result_o), 32'h1);
        cyc();
        chk("stall_hold", 32'(bus.result_o), 32'h1);
        bus.ready_i = 1'b1;
        cyc();
        chk("release_result", 32'(bus.result_o), 32'h2);
        chk("release_ready", 32'(bus.ready_o), 32'd1);
        cyc();
        chk("release_empty", 32'(bus.valid_o), 32'd0);

        // Flush with both entries full and a coincident input.
        saved = exp_status;
        bus.ready_i = 1'b0;
        push(4'h5, 1'b0, 1'b0, 1'b0, 3'd1);
        cyc();
        push(4'h6, 1'b0, 1'b0, 1'b0, 3'd2);
        cyc();
        push(4'h0, 1'b1, 1'b1, 1'b1, 3'd7);
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("flush_valid", 32'(bus.valid_o), 32'd0);
        chk("flush_ready", 32'(bus.ready_o), 32'd1);
        chk("flush_status", 32'(bus.status_o), 32'(saved));

        // Flush while ready_o is high: the input would otherwise have been accepted.
        push(4'h7, 1'b0, 1'b0, 1'b0, 3'd3);
        cyc();
        push(4'h0, 1'b1, 1'b1, 1'b1, 3'd6);
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("flush2_valid", 32'(bus.valid_o), 32'd0);
        chk("flush2_status", 32'(bus.status_o), 32'(saved));
        cyc();

        // Reset overrides flush and a full buffer.
        push(4'h9, 1'b1, 1'b0, 1'b1, 3'd1);
        cyc();
        push(4'hA, 1'b0, 1'b1, 1'b1, 3'd2);
        cyc();
        rst_n = 1'b0;
        bus.flush_i = 1'b1;
        cyc();
        check_reset_values("midreset");
        rst_n = 1'b1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        cyc();

        // Random traffic with random backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            bus.valid_i     = 1'($urandom_range(0, 1));
            bus.result_i    = 4'($urandom_range(0, 15));
            bus.carry_i     = 1'($urandom_range(0, 1));
            bus.ovf_i       = 1'($urandom_range(0, 1));
            bus.set_flags_i = 1'($urandom_range(0, 1));
            bus.dest_i      = 3'($urandom_range(0, 7));
            bus.ready_i     = ($urandom_range(0, 9) < 7);
            bus.flush_i     = ($urandom_range(0, 29) == 0);
            cyc();
        end
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (4) cyc();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
